button_press_gen: RTL and testbench
===================================

Name: button_press_gen

Overview:
- Transmitter side of the button/LED toggle interface.
- Drives a single-bit, button-like output with a programmed number of clean press/release pulses.
- Pulse timing is fixed by parameters; the pattern is started by a start/busy/done handshake.
- Used as a stimulus source in the exam-problem benches and as an on-board auto-presser feeding toggle/LED logic.

Parameters:
- HOLD_CYCLES, 2: cycles button is held high per press; must be >= 1.
- GAP_CYCLES, 2: cycles button is held low after each press; must be >= 1.
- COUNT_W, 4: width of the press count and the sent-press counter.
- TIMER_W, 8: width of the internal hold/gap timer; must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request a sequence; sampled only in IDLE.
- num_presses  input  COUNT_W  number of presses; latched when start is accepted.
- button  output  1  generated button waveform, registered.
- busy  output  1  high while in PRESS or RELEASE.
- done  output  1  one-cycle pulse at the end of a sequence.
- presses_sent  output  COUNT_W  completed presses in the current/last sequence.

Behaviour:
- Reset (reset=0, async): state=IDLE, button=0, busy=0, done=0, presses_sent=0, timer=0, remaining=0. Applies immediately, including mid-press.
- States: IDLE, PRESS, RELEASE, DONE. All outputs are registered.
- IDLE:
  - On an edge with start=1: latch num_presses into remaining and clear presses_sent.
  - If num_presses != 0: go to PRESS, so button=1 and busy=1 after this edge.
  - If num_presses == 0: go to DONE, button stays 0.
- PRESS: button=1 for exactly HOLD_CYCLES cycles. On the last one, go to RELEASE: button=0, presses_sent+1, remaining-1.
- RELEASE: button=0 for exactly GAP_CYCLES cycles. On the last one:
  - If remaining != 0: go to PRESS.
  - Else: go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Timing:
  - Latency from accepting start to the first button rise: 1 edge.
  - Period per press: HOLD_CYCLES + GAP_CYCLES cycles.
  - done is high in the cycle after edge E(N*(HOLD_CYCLES+GAP_CYCLES)), with E0 being the start-accept edge.
- start is ignored in PRESS, RELEASE and DONE. If start is held high, a new sequence is accepted on the first edge in IDLE after DONE.
- num_presses changes after acceptance have no effect.
- presses_sent holds its final value until the next accepted start or reset. It never wraps, because at most 2^COUNT_W-1 presses can be requested.
- The button waveform is glitch-free (flop output) and is never high in IDLE or DONE.

Optional Feature:
- Macro: BUTTON_PRESS_GEN_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 sampled in PRESS or RELEASE: next edge goes to DONE, button=0, done pulses, presses_sent keeps its count (a press cut short is not counted).
  - abort has no effect in IDLE or DONE.
- When undefined: no abort port and no abort logic; behaviour is exactly as above.

Test Plan (HOLD_CYCLES=2, GAP_CYCLES=2):
1. reset=0 for 5 cycles with start=1 -> button=0, busy=0, done=0, presses_sent=0 throughout. Release reset -> first press begins one edge after start is sampled.
2. start pulse with num_presses=1, accepted at E0 -> button=1 after E0,E1; button=0 after E2,E3; presses_sent=1 after E2; busy=1 after E0..E3; done=1 only after E4; IDLE after E5.
3. num_presses=3 -> three 2-high/2-low pulses, exactly 3 rising edges on button; done after E12; presses_sent=3.
4. num_presses=0 with start -> button never rises, busy stays 0, done=1 after E0, then IDLE.
5. start re-pulsed mid-sequence with num_presses=5 during a 2-press run -> ignored: still 2 pulses, presses_sent=2. start held high continuously -> back-to-back sequences, each preceded by one done pulse.
6. reset driven to 0 mid-PRESS, between clock edges -> button=0 and busy=0 immediately, presses_sent=0. After release with no start -> stays IDLE. With the macro: abort in RELEASE of press 2 of 3 -> done next cycle, presses_sent=2.

Source files
------------

// File: rtl/button_press_gen.sv
// Button-press pattern generator: emits num_presses clean HOLD/GAP pulses on a registered
// button output. Optional abort input enabled by defining BUTTON_PRESS_GEN_ABORT_EN.
module button_press_gen #(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2,
    parameter int COUNT_W     = 4,
    parameter int TIMER_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_presses,
`ifdef BUTTON_PRESS_GEN_ABORT_EN
    input  logic               abort,
`endif
    output logic               button,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] presses_sent,
    output logic [1:0]         state_dbg
);

    // Handshake: start is a request sampled only in IDLE; acceptance is visible as busy=1
    // (or done=1 for a zero-press request) after that edge, and done pulses once per sequence.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [COUNT_W-1:0] remaining;
    logic               abort_req;

`ifdef BUTTON_PRESS_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            timer        <= '0;
            remaining    <= '0;
            button       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            presses_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    button <= 1'b0;
                    if (start) begin
                        remaining    <= num_presses;
                        presses_sent <= '0;
                        timer        <= '0;
                        if (num_presses != '0) begin
                            state  <= PRESS;
                            button <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                PRESS: begin
                    // An aborted press is cut short and deliberately not counted.
                    if (abort_req) begin
                        state     <= DONE;
                        timer     <= '0;
                        remaining <= '0;
                        button    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (timer == HOLD_LAST) begin
                        state        <= RELEASE;
                        timer        <= '0;
                        button       <= 1'b0;
                        presses_sent <= presses_sent + COUNT_W'(1);
                        remaining    <= remaining - COUNT_W'(1);
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                RELEASE: begin
                    if (abort_req) begin
                        state     <= DONE;
                        timer     <= '0;
                        remaining <= '0;
                        button    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (remaining != '0) begin
                            state  <= PRESS;
                            button <= 1'b1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    button <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    button <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_gen.sv
// Directed bench for button_press_gen with HOLD_CYCLES=2, GAP_CYCLES=2.
module tb_button_press_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] num_presses;
    logic       button;
    logic       busy;
    logic       done;
    logic [3:0] presses_sent;
    logic [1:0] state_dbg;
`ifdef BUTTON_PRESS_GEN_ABORT_EN
    logic       abort;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;

    button_press_gen #(
        .HOLD_CYCLES(2),
        .GAP_CYCLES (2),
        .COUNT_W    (4),
        .TIMER_W    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_presses (num_presses),
`ifdef BUTTON_PRESS_GEN_ABORT_EN
        .abort       (abort),
`endif
        .button      (button),
        .busy        (busy),
        .done        (done),
        .presses_sent(presses_sent),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts a sequence from IDLE and checks every cycle through the return to IDLE.
    // Edge k after acceptance: phase k%4 < 2 means button high; a press counts at phase 2.
    task automatic run_seq(input int n, input bit keep_start, input int poke_k);
        int   rises;
        logic prev;
        num_presses = 4'(n);
        start       = 1'b1;
        step();
        if (!keep_start) start = 1'b0;
        rises = 0;
        prev  = 1'b0;
        if (n == 0) begin
            check("zero_done", {7'd0, done}, 8'd1);
            check("zero_busy", {7'd0, busy}, 8'd0);
            check("zero_button", {7'd0, button}, 8'd0);
            check("zero_sent", {4'd0, presses_sent}, 8'd0);
        end else begin
            for (int k = 0; k < 4 * n; k++) begin
                if (k > 0) step();
                check("seq_button", {7'd0, button}, ((k % 4) < 2) ? 8'd1 : 8'd0);
                check("seq_busy", {7'd0, busy}, 8'd1);
                check("seq_done", {7'd0, done}, 8'd0);
                check("seq_sent", {4'd0, presses_sent}, 8'((k / 4) + (((k % 4) >= 2) ? 1 : 0)));
                if (button && !prev) rises++;
                prev = button;
                if (poke_k >= 0 && k == poke_k) begin
                    start       = 1'b1;
                    num_presses = 4'd5;
                end else if (poke_k >= 0 && k == poke_k + 1) begin
                    start = 1'b0;
                end
            end
            step();
            check("end_done", {7'd0, done}, 8'd1);
            check("end_busy", {7'd0, busy}, 8'd0);
            check("end_button", {7'd0, button}, 8'd0);
            check("end_sent", {4'd0, presses_sent}, 8'(n));
            check("end_rises", 8'(rises), 8'(n));
        end
        step();
        check("post_done", {7'd0, done}, 8'd0);
        check("post_state", {6'd0, state_dbg}, {6'd0, ST_IDLE});
        check("post_sent", {4'd0, presses_sent}, 8'(n));
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b1;
        num_presses = 4'd1;
`ifdef BUTTON_PRESS_GEN_ABORT_EN
        abort = 1'b0;
`endif
        #1 reset = 1'b0;

        // Reset held with start high: everything stays quiet.
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_button", {7'd0, button}, 8'd0);
            check("rst_busy", {7'd0, busy}, 8'd0);
            check("rst_done", {7'd0, done}, 8'd0);
            check("rst_sent", {4'd0, presses_sent}, 8'd0);
            check("rst_state", {6'd0, state_dbg}, {6'd0, ST_IDLE});
        end
        reset = 1'b1;

        // First edge after release accepts the pending start; single-press timing.
        run_seq(1, 1'b0, -1);
        run_seq(3, 1'b0, -1);
        run_seq(0, 1'b0, -1);
        // start re-pulsed mid-run with a different count is ignored.
        run_seq(2, 1'b0, 3);
        // start held: back-to-back sequences, each ending with its own done pulse.
        run_seq(1, 1'b1, -1);
        run_seq(2, 1'b0, -1);

        // Asynchronous reset in the middle of the second press.
        num_presses = 4'd3;
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_button", {7'd0, button}, 8'd1);
        check("mid_sent", {4'd0, presses_sent}, 8'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_button", {7'd0, button}, 8'd0);
        check("arst_busy", {7'd0, busy}, 8'd0);
        check("arst_sent", {4'd0, presses_sent}, 8'd0);
        check("arst_state", {6'd0, state_dbg}, {6'd0, ST_IDLE});
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_state", {6'd0, state_dbg}, {6'd0, ST_IDLE});
            check("idle_button", {7'd0, button}, 8'd0);
            check("idle_busy", {7'd0, busy}, 8'd0);
        end

`ifdef BUTTON_PRESS_GEN_ABORT_EN
        // Abort during the release of press 2 of 3.
        num_presses = 4'd3;
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("ab_pre_button", {7'd0, button}, 8'd0);
        check("ab_pre_sent", {4'd0, presses_sent}, 8'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_done", {7'd0, done}, 8'd1);
        check("ab_busy", {7'd0, busy}, 8'd0);
        check("ab_button", {7'd0, button}, 8'd0);
        check("ab_sent", {4'd0, presses_sent}, 8'd2);
        step();
        check("ab_state", {6'd0, state_dbg}, {6'd0, ST_IDLE});
        check("ab_done_clr", {7'd0, done}, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
